// File: rtl/hms_timekeeper.sv
// ---------------------------------------------------------------------------
// hms_timekeeper
//   Hours:minutes:seconds timekeeper with a 1 Hz prescaler and a two-state
//   mode FSM. CLOCK mode counts time on every prescaler tick. SETUP mode
//   freezes the prescaler and lets the user step through the fields with the
//   position, increment and decrement pulses.
//
//   Optional feature: define HMS_TIMEKEEPER_ALARM_EN to build the alarm
//   comparator and flag. Without it the alarm inputs are ignored and o_alarm
//   is tied low.
//
//   Parameters:
//     CLK_HZ  input clock frequency; prescaler terminal count is CLK_HZ-1.
//             Must be at least 2.
//     HR_MAX  hour wrap value (23 -> 24 h clock, 11 -> 00..11 clock).
// ---------------------------------------------------------------------------
module hms_timekeeper #(
    parameter int CLK_HZ = 50000000,
    parameter int HR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_mode_pls,
    input  logic       i_pos_pls,
    input  logic       i_inc_pls,
    input  logic       i_dec_pls,
    input  logic [4:0] i_alarm_hr,
    input  logic [5:0] i_alarm_min,
    input  logic       i_alarm_clr,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hr,
    output logic       o_mode,
    output logic [1:0] o_position,
    output logic       o_sec_tick,
    output logic       o_rollover,
    output logic       o_alarm
);

    typedef enum logic {
        MODE_CLOCK = 1'b0,
        MODE_SETUP = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        POS_SEC = 2'd0,
        POS_MIN = 2'd1,
        POS_HR  = 2'd2
    } pos_t;

    localparam int                 PRESC_W  = $clog2(CLK_HZ);
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_HZ - 1);
    localparam logic [5:0]         SM_TOP   = 6'd59;
    localparam logic [4:0]         HR_TOP   = 5'(HR_MAX);

    // Field step with wrap in both directions; no carry leaves the field.
    function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                             input logic       up,
                                             input logic [5:0] top);
        if (up) begin
            return (v == top) ? 6'd0 : v + 6'd1;
        end
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    mode_t              r_mode;
    mode_t              w_mode_nxt;
    pos_t               r_pos;
    pos_t               w_pos_nxt;
    logic [PRESC_W-1:0] r_presc;
    logic [5:0]         r_sec;
    logic [5:0]         r_min;
    logic [4:0]         r_hr;
    logic [5:0]         w_sec_nxt;
    logic [5:0]         w_min_nxt;
    logic [4:0]         w_hr_nxt;
    logic               w_wrap;
    logic               r_sec_tick;
    logic               r_rollover;
    logic               w_in_setup;
    logic               w_tick;
    logic               w_enter_setup;
    logic               w_edit_inc;
    logic               w_edit_dec;

    assign w_in_setup    = (r_mode == MODE_SETUP);
    // The tick is the prescaler terminal count, only ever seen in CLOCK mode.
    assign w_tick        = !w_in_setup && (r_presc == PRESC_TC);
    assign w_enter_setup = !w_in_setup && i_mode_pls;
    // Simultaneous inc and dec cancel out.
    assign w_edit_inc    = w_in_setup && i_inc_pls && !i_dec_pls;
    assign w_edit_dec    = w_in_setup && i_dec_pls && !i_inc_pls;

    // Mode FSM state register (mode plus setup position).
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_n) begin
            r_mode <= MODE_CLOCK;
            r_pos  <= POS_SEC;
        end else begin
            r_mode <= w_mode_nxt;
            r_pos  <= w_pos_nxt;
        end
    end

    // Mode FSM next state: toggle on mode pulse, step position only in SETUP.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_mode_nxt = r_mode;
        w_pos_nxt  = r_pos;
        case (r_mode)
            MODE_CLOCK: begin
                if (i_mode_pls) begin
                    w_mode_nxt = MODE_SETUP;
                    w_pos_nxt  = POS_SEC;
                end
            end
            MODE_SETUP: begin
                if (i_pos_pls) begin
                    case (r_pos)
                        POS_SEC: w_pos_nxt = POS_MIN;
                        POS_MIN: w_pos_nxt = POS_HR;
                        default: w_pos_nxt = POS_SEC;
                    endcase
                end
                if (i_mode_pls) begin
                    w_mode_nxt = MODE_CLOCK;
                end
            end
            default: begin
                w_mode_nxt = MODE_CLOCK;
                w_pos_nxt  = POS_SEC;
            end
        endcase
    end

    // Prescaler: free-runs in CLOCK, parked at 0 in SETUP and on any mode change
    // so the first tick after returning to CLOCK is a full period away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_in_setup || i_mode_pls || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Next time value: tick-driven count with full carry chain in CLOCK,
    // single-field edit without carry in SETUP.
    always_comb begin
        w_sec_nxt = r_sec;
        w_min_nxt = r_min;
        w_hr_nxt  = r_hr;
        w_wrap    = 1'b0;
        if (w_tick) begin
            if (r_sec == SM_TOP) begin
                w_sec_nxt = 6'd0;
                if (r_min == SM_TOP) begin
                    w_min_nxt = 6'd0;
                    if (r_hr == HR_TOP) begin
                        w_hr_nxt = 5'd0;
                        w_wrap   = 1'b1;
                    end else begin
                        w_hr_nxt = r_hr + 5'd1;
                    end
                end else begin
                    w_min_nxt = r_min + 6'd1;
                end
            end else begin
                w_sec_nxt = r_sec + 6'd1;
            end
        end else if (w_edit_inc || w_edit_dec) begin
            case (r_pos)
                POS_SEC: w_sec_nxt = wrap_step(r_sec, w_edit_inc, SM_TOP);
                POS_MIN: w_min_nxt = wrap_step(r_min, w_edit_inc, SM_TOP);
                POS_HR:  w_hr_nxt  = 5'(wrap_step({1'b0, r_hr}, w_edit_inc,
                                                  {1'b0, HR_TOP}));
                default: ;
            endcase
        end
    end

    // Time registers and the one-cycle tick/rollover strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec      <= 6'd0;
            r_min      <= 6'd0;
            r_hr       <= 5'd0;
            r_sec_tick <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_sec      <= w_sec_nxt;
            r_min      <= w_min_nxt;
            r_hr       <= w_hr_nxt;
            r_sec_tick <= w_tick;
            r_rollover <= w_wrap;
        end
    end

`ifdef HMS_TIMEKEEPER_ALARM_EN
    logic r_alarm;
    logic w_alarm_set;

    // Alarm fires when a tick lands exactly on alarm_hr:alarm_min:00.
    assign w_alarm_set = w_tick && (w_hr_nxt == i_alarm_hr) &&
                         (w_min_nxt == i_alarm_min) && (w_sec_nxt == 6'd0);

    // Alarm flag: set has priority over clear and over SETUP entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm <= 1'b0;
        end else if (w_alarm_set) begin
            r_alarm <= 1'b1;
        end else if (i_alarm_clr || w_enter_setup) begin
            r_alarm <= 1'b0;
        end
    end

    assign o_alarm = r_alarm;
`else
    // Alarm inputs are kept on the port list but intentionally unused.
    logic w_unused_alarm;
    assign w_unused_alarm = ^{i_alarm_hr, i_alarm_min, i_alarm_clr, w_enter_setup};
    assign o_alarm        = 1'b0;
`endif

    assign o_sec      = r_sec;
    assign o_min      = r_min;
    assign o_hr       = r_hr;
    assign o_mode     = r_mode;
    assign o_position = r_pos;
    assign o_sec_tick = r_sec_tick;
    assign o_rollover = r_rollover;

endmodule

// File: doc/hms_timekeeper.md
HMS_TIMEKEEPER -- requirements
Module: hms_timekeeper

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency; sets the 1 Hz prescaler terminal count; SHALL be >=2.
REQ-002 Parameter HR_MAX, default 23, hour wrap value; 23 gives a 24 h clock, 11 gives a 12 h clock (00..11).
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_mode_pls  input  1  single-cycle pulse (debounced upstream); toggles CLOCK/SETUP.
REQ-006 i_pos_pls  input  1  single-cycle pulse; advances the setup position.
REQ-007 i_inc_pls  input  1  single-cycle pulse; increments the selected field in SETUP.
REQ-008 i_dec_pls  input  1  single-cycle pulse; decrements the selected field in SETUP.
REQ-009 i_alarm_hr  input  5  alarm hour.
REQ-010 i_alarm_min  input  6  alarm minute.
REQ-011 i_alarm_clr  input  1  pulse; clears o_alarm.
REQ-012 o_sec  output  6  seconds, 0..59.
REQ-013 o_min  output  6  minutes, 0..59.
REQ-014 o_hr  output  5  hours, 0..HR_MAX.
REQ-015 o_mode  output  1  0=CLOCK, 1=SETUP.
REQ-016 o_position  output  2  0=SEC, 1=MIN, 2=HR; code 3 never output.
REQ-017 o_sec_tick  output  1  one-cycle pulse per prescaler terminal count.
REQ-018 o_rollover  output  1  one-cycle pulse when HR_MAX:59:59 wraps to 00:00:00 in CLOCK mode.
REQ-019 o_alarm  output  1  alarm flag.

Function
REQ-020 All outputs SHALL be registered; updates SHALL be visible on the cycle after the causing event.
REQ-021 Prescaler: count 0..CLK_HZ-1; o_sec_tick SHALL be asserted in the cycle after the count equals CLK_HZ-1, and the count SHALL return to 0.
REQ-022 In SETUP, the prescaler SHALL be held at 0 and o_sec_tick SHALL stay low; after returning to CLOCK, the first tick SHALL come exactly CLK_HZ cycles later.
REQ-023 CLOCK mode, on a tick: sec +1; at 59 sec SHALL wrap to 0 and carry into min; at min 59 with a carry, min SHALL wrap to 0 and carry into hr; hr at HR_MAX with a carry SHALL wrap to 0. All carries SHALL resolve in the same cycle.
REQ-024 Mode FSM: i_mode_pls SHALL toggle o_mode; entering SETUP SHALL force o_position=SEC.
REQ-025 i_pos_pls in SETUP SHALL step SEC->MIN->HR->SEC; it SHALL be ignored in CLOCK.
REQ-026 SETUP inc: the selected field SHALL go +1 and wrap max->0; dec: the selected field SHALL go -1 and wrap 0->max; there SHALL be no carry or borrow into other fields; both pulses SHALL be ignored in CLOCK.
REQ-027 i_inc_pls and i_dec_pls in the same cycle SHALL leave the field unchanged.
REQ-028 A tick and i_mode_pls in the same cycle: the tick increment SHALL apply, then the mode SHALL toggle.
REQ-029 i_pos_pls together with i_inc_pls/i_dec_pls: the edit SHALL apply to the old position and the position SHALL advance.
REQ-030 o_rollover SHALL fire only on a tick-driven wrap, never on a setup edit.

Reset
REQ-031 On rst_n low, asynchronously: o_sec=0, o_min=0, o_hr=0, o_mode=0, o_position=0, o_sec_tick=0, o_rollover=0, o_alarm=0, prescaler=0.
REQ-032 Reset asserted mid-count or mid-setup SHALL abort everything; after release, the first tick SHALL come CLK_HZ cycles later.

Configuration
REQ-033 Macro HMS_TIMEKEEPER_ALARM_EN defined: o_alarm SHALL set when a CLOCK-mode tick makes time equal i_alarm_hr:i_alarm_min:00. It SHALL hold until i_alarm_clr or entry to SETUP. If set and clear occur in the same cycle, set SHALL win.
REQ-034 Macro undefined: the alarm ports SHALL remain present, the alarm inputs SHALL be ignored, o_alarm SHALL be tied 0, and no alarm logic SHALL be synthesised.

Verification (CLK_HZ=10, HR_MAX=23 unless stated)
REQ-035 Release reset, run 30 cycles -> ticks at cycles 10, 20, 30; o_sec=3.
REQ-036 Setup to 23:59:58, return to CLOCK, wait 2 ticks -> 00:00:00; o_rollover high for exactly 1 cycle.
REQ-037 HR_MAX=11: setup hr=11, then inc -> hr=0; then dec -> hr=11; min unchanged.
REQ-038 SETUP, position MIN=0, dec -> min=59, hr unchanged; inc+dec in the same cycle -> min stays 59.
REQ-039 ALARM_EN, alarm 00:01, start 00:00:58, two ticks -> o_alarm=1; i_alarm_clr -> 0; clr and set in the same cycle -> 1.
REQ-040 Assert rst_n low at prescaler count 7 with time 05:06:07 -> all outputs 0 immediately; next tick 10 cycles after release.
